// File: rtl/nanorv32_prog_loader_pkg.sv
// nanorv32 program loader: shared state encoding, header size and word-geometry helper.
package nanorv32_prog_loader_pkg;

  typedef enum logic [1:0] {
    LDR_HDR  = 2'd0,
    LDR_DATA = 2'd1,
    LDR_DONE = 2'd2,
    LDR_ERR  = 2'd3
  } ldr_state_t;

  localparam int LDR_HDR_BYTES = 4;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/nanorv32_byte_packer.sv
// Byte-to-word assembler: collects bytes little-endian into a code-memory word
// and flags the byte that completes it.
module nanorv32_byte_packer
  import nanorv32_prog_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  word_done,
  output logic [DATA_WIDTH-1:0] word_data
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]      byte_idx;
  logic [DATA_WIDTH-1:0] partial;

  // word_data is the partial word with the incoming byte merged into its lane
  always_comb begin
    word_data = partial;
    for (int k = 0; k < BPW; k++) begin
      if (byte_idx == IDX_W'(k)) begin
        word_data[8*k +: 8] = byte_data;
      end
    end
    word_done = byte_valid && (byte_idx == IDX_W'(BPW - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      partial  <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      partial  <= '0;
    end else if (byte_valid) begin
      partial  <= word_data;
      byte_idx <= word_done ? '0 : byte_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/nanorv32_prog_loader.sv
// Code-memory loader: parses a length header, streams payload words into the
// code RAM from address 0 and holds the CPU in reset until the image is complete.
module nanorv32_prog_loader
  import nanorv32_prog_loader_pkg::*;
#(
  parameter int ADDR_SIZE      = 15,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  input  logic [7:0]                                 in_data,
  output logic                                       in_ready,
  input  logic                                       reload,
  output logic                                       mem_we,
  output logic [ADDR_SIZE-$clog2(DATA_WIDTH/8)-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]                      mem_wdata,
  output logic                                       cpu_rst_n,
  output logic                                       done,
  output logic                                       error,
  output logic [31:0]                                words_loaded
);

  localparam int          BPW       = bytes_per_word(DATA_WIDTH);
  localparam int          AW        = ADDR_SIZE - $clog2(BPW);
  localparam logic [32:0] MAX_WORDS = 33'd1 << AW;
  localparam bit          WD_EN     = TIMEOUT_CYCLES > 0;
  localparam int          WD_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int          WD_LIMIT  = WD_EN ? TIMEOUT_CYCLES - 1 : 0;

  ldr_state_t state, next_state;

  logic            accept, hdr_accept, data_accept, hdr_last;
  logic            active, reload_go, last_word, wd_fire;
  logic [1:0]      hdr_idx;
  logic [31:0]     len_q, hdr_len;
  logic            armed;
  logic [WD_W-1:0] wd_cnt;
  logic            word_done;
  logic [DATA_WIDTH-1:0] packed_word;

  assign accept      = in_valid && in_ready;
  assign active      = (state == LDR_HDR) || (state == LDR_DATA);
  assign hdr_accept  = accept && (state == LDR_HDR);
  assign data_accept = accept && (state == LDR_DATA);
  assign hdr_len     = {in_data, len_q[31:8]};
  assign hdr_last    = hdr_accept && (hdr_idx == 2'(LDR_HDR_BYTES - 1));
  assign reload_go   = reload && ((state == LDR_DONE) || (state == LDR_ERR));
  assign last_word   = mem_we && ((words_loaded + 32'd1) == len_q);
  // An accepted byte on the would-be timeout cycle wins over the watchdog
  assign wd_fire     = WD_EN && armed && active && !accept && (wd_cnt == WD_W'(WD_LIMIT));

  nanorv32_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state != LDR_DATA),
    .byte_valid (data_accept),
    .byte_data  (in_data),
    .word_done  (word_done),
    .word_data  (packed_word)
  );

  // in_ready is a registered decode of the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LDR_HDR;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == LDR_HDR) || (next_state == LDR_DATA);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LDR_HDR: begin
        if (wd_fire) begin
          next_state = LDR_ERR;
        end else if (hdr_last) begin
          if (hdr_len == 32'd0) begin
            next_state = LDR_DONE;
          end else if ({1'b0, hdr_len} > MAX_WORDS) begin
            next_state = LDR_ERR;
          end else begin
            next_state = LDR_DATA;
          end
        end
      end
      LDR_DATA: begin
        if (last_word) begin
          next_state = LDR_DONE;
        end else if (wd_fire) begin
          next_state = LDR_ERR;
        end
      end
      LDR_DONE, LDR_ERR: begin
        if (reload) begin
          next_state = LDR_HDR;
        end
      end
      default: next_state = LDR_HDR;
    endcase
  end

  always_comb begin
    done      = (state == LDR_DONE);
    error     = (state == LDR_ERR);
    cpu_rst_n = (state == LDR_DONE);
  end

  // mem_addr advances at the end of the mem_we cycle so it is stable while writing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx      <= '0;
      len_q        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else if (reload_go) begin
      hdr_idx      <= '0;
      len_q        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      words_loaded <= '0;
    end else begin
      if (hdr_accept) begin
        hdr_idx <= hdr_idx + 2'd1;
        len_q   <= hdr_len;
      end
      mem_we <= word_done;
      if (word_done) begin
        mem_wdata <= packed_word;
      end
      if (mem_we) begin
        mem_addr     <= mem_addr + AW'(1);
        words_loaded <= words_loaded + 32'd1;
      end
    end
  end

  // Watchdog arms on the first header byte so an idle host never trips it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      wd_cnt <= '0;
    end else if (reload_go) begin
      armed  <= 1'b0;
      wd_cnt <= '0;
    end else begin
      if (hdr_accept) begin
        armed <= 1'b1;
      end
      if (accept) begin
        wd_cnt <= '0;
      end else if (armed && active) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nanorv32_prog_loader.sv
// Randomized and directed checks of the program loader against a byte-stream reference model,
// using a 32-bit-word instance (sel 0) and a 16-bit-word instance (sel 1).
module tb_nanorv32_prog_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        va = 1'b0, rla = 1'b0, ra, wea, cra, dna, era;
  logic [7:0]  da = 8'h00;
  logic [12:0] addr_a;
  logic [31:0] wd_a, wl_a;

  logic        vb = 1'b0, rlb = 1'b0, rb, web, crb, dnb, erb;
  logic [7:0]  db = 8'h00;
  logic [13:0] addr_b;
  logic [15:0] wd_b;
  logic [31:0] wl_b;

  nanorv32_prog_loader #(.ADDR_SIZE(15), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_data(da), .in_ready(ra), .reload(rla),
    .mem_we(wea), .mem_addr(addr_a), .mem_wdata(wd_a), .cpu_rst_n(cra), .done(dna),
    .error(era), .words_loaded(wl_a));

  nanorv32_prog_loader #(.ADDR_SIZE(15), .DATA_WIDTH(16), .TIMEOUT_CYCLES(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_data(db), .in_ready(rb), .reload(rlb),
    .mem_we(web), .mem_addr(addr_b), .mem_wdata(wd_b), .cpu_rst_n(crb), .done(dnb),
    .error(erb), .words_loaded(wl_b));

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned cap_addr_a[$], cap_data_a[$], cap_addr_b[$], cap_data_b[$];
  int cpu_hi_a = 0, cpu_hi_b = 0;
  bit load_act_a = 1'b0, load_act_b = 1'b0;
  logic [7:0]  pay_q[$];
  logic [31:0] exp_q[$];

  // Monitor: record every write strobe and any CPU release while a load is running
  always @(negedge clk) begin
    if (wea) begin cap_addr_a.push_back(32'(addr_a)); cap_data_a.push_back(wd_a); end
    if (web) begin cap_addr_b.push_back(32'(addr_b)); cap_data_b.push_back(32'(wd_b)); end
    if (load_act_a && cra) cpu_hi_a++;
    if (load_act_b && crb) cpu_hi_b++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got still running, expected finished");
    $fatal(1, "[TB] simulation stalled");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int sel);     return (sel == 0) ? ra  : rb;  endfunction
  function automatic logic isDone(input int sel);  return (sel == 0) ? dna : dnb; endfunction
  function automatic logic isErr(input int sel);   return (sel == 0) ? era : erb; endfunction
  function automatic logic weOf(input int sel);    return (sel == 0) ? wea : web; endfunction
  function automatic logic cpuOf(input int sel);   return (sel == 0) ? cra : crb; endfunction
  function automatic logic [31:0] wlOf(input int sel); return (sel == 0) ? wl_a : wl_b; endfunction
  function automatic int capSize(input int sel);   return (sel == 0) ? cap_addr_a.size() : cap_addr_b.size(); endfunction
  function automatic int cpuHi(input int sel);     return (sel == 0) ? cpu_hi_a : cpu_hi_b; endfunction
  function automatic int unsigned capAddrAt(input int sel, input int i);
    return (sel == 0) ? cap_addr_a[i] : cap_addr_b[i];
  endfunction
  function automatic int unsigned capDataAt(input int sel, input int i);
    return (sel == 0) ? cap_data_a[i] : cap_data_b[i];
  endfunction

  task automatic setLoadAct(input int sel, input bit v);
    if (sel == 0) load_act_a = v; else load_act_b = v;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge after the byte is taken
  task automatic sendByte(input int sel, input logic [7:0] b);
    int n;
    n = 0;
    if (sel == 0) begin va = 1'b1; da = b; end else begin vb = 1'b1; db = b; end
    while (!rdy(sel) && n < 64) begin @(negedge clk); n++; end
    if (!rdy(sel)) checkOutput("ready_wait", rdy(sel), 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (sel == 0) va = 1'b0; else vb = 1'b0;
  endtask

  task automatic pulseReload(input int sel);
    if (sel == 0) rla = 1'b1; else rlb = 1'b1;
    @(negedge clk);
    if (sel == 0) rla = 1'b0; else rlb = 1'b0;
    checkOutput("reload_cpu_low", cpuOf(sel), 1'b0);
    checkOutput("reload_done_clr", isDone(sel), 1'b0);
    checkOutput("reload_err_clr", isErr(sel), 1'b0);
    checkOutput("reload_wl_clr", wlOf(sel), 32'd0);
    checkOutput("reload_ready", rdy(sel), 1'b1);
  endtask

  // Reference: word i is bytes i*bpw .. i*bpw+bpw-1 of the payload, little-endian
  task automatic buildExpected(input int bpw, input int nwords);
    logic [31:0] w;
    exp_q = {};
    for (int i = 0; i < nwords; i++) begin
      w = 32'd0;
      for (int k = 0; k < bpw; k++) w = w | (32'(pay_q[i*bpw + k]) << (8*k));
      exp_q.push_back(w);
    end
  endtask

  task automatic checkWrites(input int sel, input int base);
    int n;
    n = capSize(sel) - base;
    checkOutput("write_count", n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      checkOutput("write_addr", capAddrAt(sel, base + i), i);
      checkOutput("write_data", capDataAt(sel, base + i), exp_q[i]);
    end
  endtask

  // One complete load: header, payload with random gaps, then outcome checks
  task automatic applyStimulus(input int sel, input logic [31:0] len, input int maxgap, input bit use_fixed);
    int bpw, base, hi0, outcome;
    logic [32:0] maxw;
    bpw  = (sel == 0) ? 4 : 2;
    maxw = (sel == 0) ? 33'd8192 : 33'd16384;
    if (isDone(sel) || isErr(sel)) pulseReload(sel);
    base = capSize(sel);
    hi0  = cpuHi(sel);
    outcome = (len == 0) ? 0 : (({1'b0, len} > maxw) ? 1 : 2);
    if (!use_fixed) begin
      pay_q = {};
      if (outcome == 2) for (int i = 0; i < int'(len) * bpw; i++) pay_q.push_back(8'($urandom));
    end
    setLoadAct(sel, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idleCycles(int'($urandom_range(0, maxgap)));
      sendByte(sel, len[8*i +: 8]);
    end
    if (outcome == 2) begin
      foreach (pay_q[i]) begin
        idleCycles(int'($urandom_range(0, maxgap)));
        sendByte(sel, pay_q[i]);
      end
    end
    setLoadAct(sel, 1'b0);
    if (outcome == 2) begin
      checkOutput("we_after_last", weOf(sel), 1'b1);
      checkOutput("done_not_early", isDone(sel), 1'b0);
    end
    @(negedge clk);
    exp_q = {};
    if (outcome == 2) buildExpected(bpw, int'(len));
    checkOutput("done", isDone(sel), outcome != 1);
    checkOutput("error", isErr(sel), outcome == 1);
    checkOutput("cpu_rst_n", cpuOf(sel), outcome != 1);
    checkOutput("ready_idle", rdy(sel), 1'b0);
    checkOutput("words_loaded", wlOf(sel), (outcome == 2) ? len : 32'd0);
    checkWrites(sel, base);
    checkOutput("cpu_held_in_load", cpuHi(sel) - hi0, 0);
  endtask

  initial begin
    int base;
    logic [7:0] b;

    #12;
    checkOutput("rst_ready", ra, 1'b0);
    checkOutput("rst_we", wea, 1'b0);
    checkOutput("rst_addr", addr_a, 13'd0);
    checkOutput("rst_wdata", wd_a, 32'd0);
    checkOutput("rst_cpu", cra, 1'b0);
    checkOutput("rst_done", dna, 1'b0);
    checkOutput("rst_error", era, 1'b0);
    checkOutput("rst_wl", wl_a, 32'd0);
    checkOutput("rst_ready_b", rb, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_first_edge", ra, 1'b1);
    checkOutput("ready_first_edge_b", rb, 1'b1);

    $display("[TB] two-word image");
    pay_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    applyStimulus(0, 32'd2, 0, 1'b1);

    $display("[TB] empty image and oversize headers");
    applyStimulus(0, 32'd0, 2, 1'b0);
    applyStimulus(0, 32'd8193, 0, 1'b0);
    applyStimulus(1, 32'hFFFF_FFFF, 1, 1'b0);

    $display("[TB] 16-bit words");
    pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    applyStimulus(1, 32'd3, 0, 1'b1);

    $display("[TB] watchdog");
    pulseReload(0);
    base = capSize(0);
    sendByte(0, 8'h01); sendByte(0, 8'h00); sendByte(0, 8'h00); sendByte(0, 8'h00);
    sendByte(0, 8'h11); sendByte(0, 8'h22);
    idleCycles(15);
    checkOutput("wd_quiet_15", era, 1'b0);
    idleCycles(1);
    checkOutput("wd_fire_16", era, 1'b1);
    checkOutput("wd_cpu_low", cra, 1'b0);
    exp_q = {};
    checkWrites(0, base);

    pulseReload(0);
    base = capSize(0);
    sendByte(0, 8'h01); sendByte(0, 8'h00); sendByte(0, 8'h00); sendByte(0, 8'h00);
    sendByte(0, 8'h11); sendByte(0, 8'h22);
    idleCycles(15);
    sendByte(0, 8'h33);
    checkOutput("wd_byte_wins", era, 1'b0);
    sendByte(0, 8'h44);
    @(negedge clk);
    checkOutput("wd_alive_done", dna, 1'b1);
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    buildExpected(4, 1);
    checkWrites(0, base);

    pulseReload(0);
    idleCycles(40);
    checkOutput("idle_unarmed", era, 1'b0);
    applyStimulus(0, 32'd1, 3, 1'b0);

    $display("[TB] full-size header and mid-load reset");
    pulseReload(0);
    base = capSize(0);
    sendByte(0, 8'h00); sendByte(0, 8'h20); sendByte(0, 8'h00); sendByte(0, 8'h00);
    checkOutput("len_max_no_err", era, 1'b0);
    checkOutput("len_max_ready", ra, 1'b1);
    pay_q = {};
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      pay_q.push_back(b);
      sendByte(0, b);
    end
    buildExpected(4, 1);
    checkWrites(0, base);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_ready", ra, 1'b0);
    checkOutput("arst_we", wea, 1'b0);
    checkOutput("arst_addr", addr_a, 13'd0);
    checkOutput("arst_wdata", wd_a, 32'd0);
    checkOutput("arst_cpu", cra, 1'b0);
    checkOutput("arst_wl", wl_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(3);
    checkOutput("arst_ready_back", ra, 1'b1);
    checkWrites(0, base);
    applyStimulus(0, 32'd2, 2, 1'b0);
    applyStimulus(0, 32'd3, 2, 1'b0);

    $display("[TB] randomized loads");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i % 2, 32'($urandom_range(0, 6)), int'($urandom_range(0, 5)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nanorv32_prog_loader.md
# nanorv32_prog_loader

Hardware program-memory loader for the nanorv32 simple chip, replacing bench-side backdoor loading of the code RAM. It accepts a byte stream (length header plus little-endian payload) over a valid/ready interface, assembles bytes into code-memory words, and writes them sequentially from word address 0. It holds the CPU in reset until the image is complete. A byte-gap watchdog flags stalled transfers, and a reload request restarts the sequence. Word width, code-memory size and timeout are parametrised.

## Interface
Parameters:
- ADDR_SIZE, 15: code-memory byte-address width (half of the 16-bit nanorv32 space).
- DATA_WIDTH, 32: code-memory word width; a multiple of 8, at least 8.
- TIMEOUT_CYCLES, 1024: maximum idle cycles between accepted bytes while a load is in progress; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- mem_we  out  1  code-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_SIZE-log2(DATA_WIDTH/8)  word address.
- mem_wdata  out  DATA_WIDTH  assembled word.
- cpu_rst_n  out  1  CPU reset, active-low; low unless the state is DONE.
- done  out  1  image loaded successfully.
- error  out  1  load aborted (oversize image or timeout).
- words_loaded  out  32  count of words written in the current load.

## Operation
- The handshake completes a byte transfer when in_valid and in_ready are both high on a rising clk edge.
- State HDR:
  - The loader accepts 4 bytes, little-endian, forming LEN, a 32-bit word count.
  - On the 4th byte: if LEN is 0, go to DONE. If LEN exceeds 2^(mem_addr width), go to ERR. Otherwise go to DATA.
- State DATA:
  - The loader accepts bytes in groups of BPW = DATA_WIDTH/8. Byte k of a group goes to mem_wdata[8k+7:8k].
  - On the last byte of a group: pulse mem_we with the current mem_addr, then increment mem_addr and words_loaded.
  - When words_loaded reaches LEN, go to DONE.
- State DONE: in_ready=0, done=1, cpu_rst_n=1.
- State ERR: in_ready=0, error=1, cpu_rst_n=0.
- reload in DONE or ERR: go to HDR and clear mem_addr, words_loaded, done, error and the byte index. cpu_rst_n goes low in the same cycle the state changes.
- reload in HDR or DATA is ignored.
- Watchdog:
  - It counts cycles in HDR or DATA without an accepted byte and clears on every accepted byte.
  - It counts only after the first header byte has been accepted, so the loader can wait indefinitely for a host to start.
  - When the count reaches TIMEOUT_CYCLES, go to ERR.
  - If a byte is accepted in the same cycle the count would reach TIMEOUT_CYCLES, the byte wins and no timeout occurs.
- Arithmetic: LEN is compared as 32-bit unsigned. The mem_addr increment never wraps, because the oversize check runs before DATA.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, done=0, error=0, words_loaded=0. The state is HDR.
- in_ready rises on the first clk edge after rst_n deasserts. It is a registered state decode, with no combinational path from in_valid.
- In HDR and DATA, in_ready stays high every cycle, so a sustained stream transfers 1 byte per cycle.
- mem_we is registered: it is high in the cycle after the edge that accepted the last byte of a group. mem_addr and mem_wdata are stable while mem_we is high.
- After the final word:
  - done=1 and cpu_rst_n=1 appear one cycle after the final mem_we pulse.
  - The CPU therefore sees reset release no earlier than two edges after the final byte is accepted.
- error asserts on the edge that detects the fault and stays high until reload or rst_n.
- rst_n asserted mid-load: all outputs return to their reset values immediately (asynchronously). A partially assembled word is discarded and no mem_we is generated.

## Structure
- Add to nanorv32_parameters.v:
  - state encodings: LDR_HDR, LDR_DATA, LDR_DONE, LDR_ERR;
  - a header-length constant of 4 bytes.
- Sub-module nanorv32_byte_packer: a byte-to-word shift/assemble unit. It holds the byte index and the partial word, and produces a word-complete strobe. The top level holds the FSM, address/count registers and watchdog.
- The top level is instantiated in nanorv32_simple ahead of U_CODE_MEM. It drives the RAM write port while cpu_rst_n is low.

## Test plan
- Header 02 00 00 00, payload 13 00 00 00 6F 00 00 00 -> two mem_we pulses: addr 0 data 0x00000013, then addr 1 data 0x0000006F. Then done=1, cpu_rst_n=1, words_loaded=2.
- Header 00 00 00 00 -> DONE with no mem_we pulses.
- Header LEN = 2^13+1 (ADDR_SIZE=15, DATA_WIDTH=32) -> error=1 after the 4th byte, no writes, cpu_rst_n stays 0.
- TIMEOUT_CYCLES=16, LEN=1, stream stops after 2 payload bytes -> error=1 exactly 16 cycles after the last accepted byte. A byte arriving on cycle 16 instead keeps the load alive.
- DATA_WIDTH=16, LEN=3, bytes AA BB CC DD EE FF -> words 0xBBAA, 0xDDCC, 0xFFEE at addresses 0, 1, 2.
- rst_n pulsed low after 5 payload bytes, then reload after DONE -> outputs at reset values, and a second full load rewrites from address 0 with cpu_rst_n low throughout the load.
